writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final (WB) stage of the 5-stage RV32I pipeline, directly downstream of the memory-access stage.
- Accepts one retiring instruction per cycle over a valid/ready handshake. Inputs are the raw loaded word (LMD), the ALU result, the PC, rd and control.
- Formats load data (byte/half extraction, sign/zero extension), selects the write-back source and drives the register-file write port.
- Also provides a forwarding tap to execute and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, instret counter width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  WB can accept this cycle
- in_pc  input  XLEN  instruction PC
- in_alu  input  XLEN  ALU result; bits [1:0] give the load byte offset
- in_lmd  input  XLEN  raw aligned memory word
- in_rd  input  5  destination register
- in_wb_sel  input  2  00 ALU, 01 MEM, 10 PC+4, 11 reserved
- in_funct3  input  3  load size/sign
- in_reg_write  input  1  instruction writes rd
- rf_stall  input  1  register-file port unavailable this cycle
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  write address
- rf_wdata  output  XLEN  write data
- fwd_valid  output  1  forwarding entry valid
- fwd_rd  output  5  forwarding register
- fwd_data  output  XLEN  forwarding data
- load_err  output  1  one-cycle pulse: illegal load funct3 committed
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset is asynchronous, active-high: rst_n=1 clears the holding register (hold_valid=0) and sets instret=0.
- While in reset, all outputs are 0, including in_ready.
- Single holding register (hold_*), loaded on handshake (in_valid && in_ready). The result is computed at load time and stored as hold_data.
- commit = hold_valid && !rf_stall.
- in_ready = !hold_valid || commit. This gives full throughput and no bubble.
- Simultaneous commit and accept: the old entry retires and the new one is captured in the same edge.
- Latency: handshake at edge N means commit is possible in cycle N+1. rf_stall holds the entry indefinitely with all hold fields stable.
- Source select:
  - 00 gives in_alu.
  - 10 gives in_pc+4, with wrap modulo 2^32.
  - 11 behaves as 00.
  - 01 gives formatted load data.
- Load formatting uses off=in_alu[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: half at off[1], sign-extended.
  - 101 LHU: half at off[1], zero-extended.
  - 010 LW: full word; off is ignored.
  - 011/110/111: data=0; hold_err is set.
- rf_we = commit && hold_reg_write && hold_rd!=0.
- rf_waddr=hold_rd and rf_wdata=hold_data are driven combinationally from the holding register. They are 0 when hold_valid=0.
- x0 writes are suppressed but still retire and count.
- fwd_valid = hold_valid && hold_reg_write && hold_rd!=0. It is independent of rf_stall, because the value is already final.
- load_err = commit && hold_err.
- instret increments by 1 on every commit, including illegal loads and non-writing instructions. It wraps from all-ones to 0.
- Reset asserted mid-stall discards the held instruction. No write occurs and instret is not incremented.

Test Plan:
- Reset, then in_valid with wb_sel=00, in_alu=0x1234, rd=5, reg_write=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234, instret=1.
- Loads with in_lmd=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80
  - LBU off=1 -> 0x0000007F
  - LH off=2 -> 0xFFFF80FF
  - LHU off=0 -> 0x00007F01
  - LW off=2 -> 0x80FF7F01
- wb_sel=10, in_pc=0xFFFFFFFC -> wdata=0x00000000. wb_sel=10, pc=0x100 -> 0x104.
- Back-to-back valid for 4 cycles with rf_stall high on cycle 2 -> in_ready low exactly while stalled. The entry is held stable, no instruction is lost or duplicated, and instret=4 afterwards.
- rd=0 with reg_write=1 -> rf_we=0, fwd_valid=0, instret increments. funct3=011 -> wdata=0 and a one-cycle load_err pulse at commit.
- rst_n pulsed high while an entry is stalled -> hold cleared, rf_we never asserted, instret=0, in_ready=0 during reset and 1 after release.

Source files
------------

// File: rtl/writeback_unit.sv
// Write-back stage of the RV32I pipeline: formats load data, picks the
// write-back source, owns the register-file write port and the instret counter.
module writeback_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_alu,
   input  logic [XLEN-1:0]  in_lmd,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_wb_sel,
   input  logic [2:0]       in_funct3,
   input  logic             in_reg_write,
   input  logic             rf_stall,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic             load_err,
   output logic [CNT_W-1:0] instret
);

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_PC4 = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic load_illegal(input logic [2:0] f3);
      return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
               f3 == F3_LBU || f3 == F3_LHU);
   endfunction

   // Byte/half extraction from the aligned word; illegal sizes yield zero.
   function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] lmd,
                                                   input logic [1:0]      off,
                                                   input logic [2:0]      f3);
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      logic [XLEN-1:0]    res;
      case (off)
         2'd0:    byte_s = lmd[7:0];
         2'd1:    byte_s = lmd[15:8];
         2'd2:    byte_s = lmd[23:16];
         default: byte_s = lmd[31:24];
      endcase
      half_s = off[1] ? lmd[31:16] : lmd[15:0];
      case (f3)
         F3_LB:   res = {{(XLEN-8){byte_s[7]}}, byte_s};
         F3_LBU:  res = {{(XLEN-8){1'b0}}, byte_s};
         F3_LH:   res = {{(XLEN-16){half_s[15]}}, half_s};
         F3_LHU:  res = {{(XLEN-16){1'b0}}, half_s};
         F3_LW:   res = lmd;
         default: res = '0;
      endcase
      return res;
   endfunction

   logic             hold_valid;
   logic [4:0]       hold_rd;
   logic             hold_reg_write;
   logic             hold_err;
   logic [XLEN-1:0]  hold_data;
   logic [CNT_W-1:0] instret_q;

   logic             commit;
   logic             ready_int;
   logic             accept;
   logic             hold_writes;
   logic [XLEN-1:0]  next_data;
   logic             next_err;
   logic [XLEN-1:0]  pc_plus4;

   assign commit      = hold_valid && !rf_stall;
   assign ready_int   = !hold_valid || commit;
   assign accept      = in_valid && ready_int;
   assign hold_writes = hold_reg_write && (hold_rd != 5'd0);

   always_comb begin
      pc_plus4  = in_pc + XLEN'(4);
      next_err  = 1'b0;
      case (in_wb_sel)
         SEL_MEM: begin
            next_data = format_load(in_lmd, in_alu[1:0], in_funct3);
            next_err  = load_illegal(in_funct3);
         end
         SEL_PC4: next_data = pc_plus4;
         default: next_data = in_alu;
      endcase
   end

   // Holding-register control and the retire counter
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         hold_valid <= 1'b0;
         instret_q  <= '0;
      end else begin
         if (accept)
            hold_valid <= 1'b1;
         else if (commit)
            hold_valid <= 1'b0;
         if (commit)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Holding-register payload; only meaningful while hold_valid is set
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_rd        <= in_rd;
         hold_reg_write <= in_reg_write;
         hold_err       <= next_err;
         hold_data      <= next_data;
      end
   end

   assign in_ready  = !rst_n && ready_int;
   assign rf_we     = commit && hold_writes;
   assign rf_waddr  = hold_valid ? hold_rd : 5'd0;
   assign rf_wdata  = hold_valid ? hold_data : '0;
   assign fwd_valid = hold_valid && hold_writes;
   assign fwd_rd    = fwd_valid ? hold_rd : 5'd0;
   assign fwd_data  = fwd_valid ? hold_data : '0;
   assign load_err  = commit && hold_err;
   assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Table-driven, scoreboarded bench for writeback_unit.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_alu;
   logic [31:0] in_lmd;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic        in_reg_write;
   logic        rf_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        load_err;
   logic [63:0] instret;

   writeback_unit #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_alu(in_alu), .in_lmd(in_lmd), .in_rd(in_rd),
      .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_reg_write(in_reg_write),
      .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .load_err(load_err), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] lmd;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic        regw;
      logic [31:0] exp_data;
      logic        exp_we;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        err;
   } exp_t;

   vec_t        vecs[12];
   exp_t        sb[$];
   exp_t        cur;
   logic [63:0] exp_cnt = 0;
   logic        acc_flag = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: commits are predicted from the queue and rf_stall.
   always @(negedge clk) begin
      exp_t e;
      logic ready_m;
      if (!rst_n) begin
         ready_m = (sb.size() == 0) || !rf_stall;
         chk("instret", instret, exp_cnt);
         chk("in_ready", {63'd0, in_ready}, {63'd0, ready_m});
         if (sb.size() != 0) begin
            e = sb[0];
            chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
            chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.we});
            if (!rf_stall) begin
               chk("rf_we", {63'd0, rf_we}, {63'd0, e.we});
               chk("load_err", {63'd0, load_err}, {63'd0, e.err});
               void'(sb.pop_front());
               exp_cnt = exp_cnt + 1;
            end else begin
               chk("rf_we_stalled", {63'd0, rf_we}, 64'd0);
               chk("load_err_stalled", {63'd0, load_err}, 64'd0);
            end
         end else begin
            chk("rf_we_idle", {63'd0, rf_we}, 64'd0);
            chk("fwd_valid_idle", {63'd0, fwd_valid}, 64'd0);
         end
         acc_flag = in_valid && ready_m;
         if (acc_flag) sb.push_back(cur);
      end else begin
         acc_flag = 1'b0;
         chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
         chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
         chk("rst_instret", instret, 64'd0);
      end
   end

   task automatic send(input int idx, input int stall_cyc);
      int n;
      int guard;
      n = stall_cyc;
      guard = 0;
      in_valid     = 1'b1;
      in_alu       = vecs[idx].alu;
      in_lmd       = vecs[idx].lmd;
      in_pc        = vecs[idx].pc;
      in_rd        = vecs[idx].rd;
      in_wb_sel    = vecs[idx].sel;
      in_funct3    = vecs[idx].f3;
      in_reg_write = vecs[idx].regw;
      cur.rd   = vecs[idx].rd;
      cur.data = vecs[idx].exp_data;
      cur.we   = vecs[idx].exp_we;
      cur.err  = vecs[idx].exp_err;
      rf_stall = (n > 0);
      while (1) begin
         @(posedge clk);
         #1;
         if (acc_flag) break;
         n--;
         rf_stall = (n > 0);
         guard++;
         if (guard > 20) begin
            chk("accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      rf_stall = 1'b0;
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      rf_stall = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      //          alu           lmd           pc            rd    sel    f3      regw  data          we    err
      vecs[0]  = '{32'h00001234, 32'h0,        32'h0,        5'd5, 2'b00, 3'b000, 1'b1, 32'h00001234, 1'b1, 1'b0};
      vecs[1]  = '{32'h00001003, 32'h80FF7F01, 32'h0,        5'd6, 2'b01, 3'b000, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0};
      vecs[2]  = '{32'h00001001, 32'h80FF7F01, 32'h0,        5'd7, 2'b01, 3'b100, 1'b1, 32'h0000007F, 1'b1, 1'b0};
      vecs[3]  = '{32'h00001002, 32'h80FF7F01, 32'h0,        5'd8, 2'b01, 3'b001, 1'b1, 32'hFFFF80FF, 1'b1, 1'b0};
      vecs[4]  = '{32'h00001000, 32'h80FF7F01, 32'h0,        5'd9, 2'b01, 3'b101, 1'b1, 32'h00007F01, 1'b1, 1'b0};
      vecs[5]  = '{32'h00001002, 32'h80FF7F01, 32'h0,        5'd10, 2'b01, 3'b010, 1'b1, 32'h80FF7F01, 1'b1, 1'b0};
      vecs[6]  = '{32'h00000000, 32'h0,        32'hFFFFFFFC, 5'd11, 2'b10, 3'b000, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[7]  = '{32'h00000000, 32'h0,        32'h00000100, 5'd12, 2'b10, 3'b000, 1'b1, 32'h00000104, 1'b1, 1'b0};
      vecs[8]  = '{32'h0000DEAD, 32'h0,        32'h0,        5'd0, 2'b00, 3'b000, 1'b1, 32'h0000DEAD, 1'b0, 1'b0};
      vecs[9]  = '{32'h00001000, 32'h80FF7F01, 32'h0,        5'd13, 2'b01, 3'b011, 1'b1, 32'h00000000, 1'b1, 1'b1};
      vecs[10] = '{32'h000055AA, 32'h0,        32'h0,        5'd14, 2'b11, 3'b000, 1'b1, 32'h000055AA, 1'b1, 1'b0};
      vecs[11] = '{32'h00000001, 32'h0,        32'h0,        5'd15, 2'b00, 3'b000, 1'b0, 32'h00000001, 1'b0, 1'b0};

      rst_n = 1'b1;
      in_valid = 1'b0; in_alu = '0; in_lmd = '0; in_pc = '0; in_rd = '0;
      in_wb_sel = '0; in_funct3 = '0; in_reg_write = 1'b0; rf_stall = 1'b0;
      cur = '{5'd0, 32'd0, 1'b0, 1'b0};
      #2;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
      chk("reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
      chk("reset_load_err", {63'd0, load_err}, 64'd0);
      chk("reset_instret", instret, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      idle(1);

      // Every table vector back to back
      for (int i = 0; i < 12; i++) send(i, 0);
      idle(3);
      chk("instret_after_table", instret, 64'd12);

      // Four back-to-back with the register file stalled on the second
      send(0, 0);
      send(1, 1);
      send(2, 0);
      send(3, 0);
      idle(3);
      chk("instret_after_stall_burst", instret, 64'd16);

      // Reset asserted while an entry sits stalled
      send(7, 0);
      in_valid = 1'b0;
      rf_stall = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("midrst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("midrst_instret", instret, 64'd0);
      sb.delete();
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      rf_stall = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      idle(2);
      send(5, 0);
      idle(2);
      chk("instret_after_reset", instret, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
